// File: rtl/alu_imm_unit.sv
// RV32I immediate decoder, integer ALU and branch comparator with a two-flop reset synchronizer.
// The datapath is purely combinational; only the reset conditioning is clocked.
module alu_imm_unit (
  input  logic        clk,
  input  logic        resetn,
  output logic        resetn_sync,
  input  logic [31:0] instr,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] imm,
  output logic [31:0] result,
  output logic        take_b
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  shamt;
  logic        eq;
  logic        lt_s;
  logic        lt_u;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] sra_val;
  logic        sync_q;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  assign shamt     = in_b[4:0];

  assign eq      = (in_a == in_b);
  assign lt_s    = ($signed(in_a) < $signed(in_b));
  assign lt_u    = (in_a < in_b);
  assign sum     = in_a + in_b;
  assign diff    = in_a - in_b;
  assign sra_val = $unsigned($signed(in_a) >>> shamt);

  always_comb begin
    imm = 32'd0;
    unique case (opcode)
      OP_LOAD, OP_ALUI, OP_JALR, OP_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'd0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = 32'd0;
    endcase
  end

  // Only register-register ops honour instr[30] as subtract; on ADDI that bit is immediate data.
  always_comb begin
    result = sum;
    if (opcode == OP_ALUR || opcode == OP_ALUI) begin
      unique case (funct3)
        F3_ADD:  result = (opcode == OP_ALUR && funct7_b5) ? diff : sum;
        F3_SLL:  result = in_a << shamt;
        F3_SLT:  result = {31'd0, lt_s};
        F3_SLTU: result = {31'd0, lt_u};
        F3_XOR:  result = in_a ^ in_b;
        F3_SR:   result = funct7_b5 ? sra_val : (in_a >> shamt);
        F3_OR:   result = in_a | in_b;
        F3_AND:  result = in_a & in_b;
        default: result = sum;
      endcase
    end
  end

  always_comb begin
    take_b = 1'b0;
    if (opcode == OP_BRANCH) begin
      unique case (funct3)
        F3_BEQ:  take_b = eq;
        F3_BNE:  take_b = ~eq;
        F3_BLT:  take_b = lt_s;
        F3_BGE:  take_b = ~lt_s;
        F3_BLTU: take_b = lt_u;
        F3_BGEU: take_b = ~lt_u;
        default: take_b = 1'b0;
      endcase
    end
  end

  // Assert immediately on resetn low, release on the second clk edge after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= 1'b0;
      resetn_sync <= 1'b0;
    end else begin
      sync_q      <= 1'b1;
      resetn_sync <= sync_q;
    end
  end

endmodule

// File: tb/tb_alu_imm_unit.sv
// Directed-vector bench for alu_imm_unit: combinational datapath table plus reset-synchronizer sequences.
module tb_alu_imm_unit;

  logic        clk;
  logic        resetn;
  logic        resetn_sync;
  logic [31:0] instr;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] imm;
  logic [31:0] result;
  logic        take_b;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_imm;
    logic [31:0] exp_result;
    logic        exp_take;
  } vec_t;

  vec_t vecs[$];

  alu_imm_unit dut (
    .clk         (clk),
    .resetn      (resetn),
    .resetn_sync (resetn_sync),
    .instr       (instr),
    .in_a        (in_a),
    .in_b        (in_b),
    .imm         (imm),
    .result      (result),
    .take_b      (take_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr = i;
    in_a  = a;
    in_b  = b;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    instr  = 32'd0;
    in_a   = 32'd0;
    in_b   = 32'd0;

    //            name          instr         in_a          in_b          imm           result        take
    vecs.push_back('{"sub",      32'h40000033, 32'd5,        32'd7,        32'h00000000, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"add",      32'h00000033, 32'd5,        32'd7,        32'h00000000, 32'd12,       1'b0});
    vecs.push_back('{"add_wrap", 32'h00000033, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{"addi_b30", 32'h40000013, 32'd5,        32'd7,        32'h00000400, 32'd12,       1'b0});
    vecs.push_back('{"srai",     32'h4000D013, 32'h80000000, 32'h00000021, 32'h00000400, 32'hC0000000, 1'b0});
    vecs.push_back('{"srli",     32'h0000D013, 32'h80000000, 32'h00000021, 32'h00000000, 32'h40000000, 1'b0});
    vecs.push_back('{"sll",      32'h00001033, 32'd1,        32'h00000025, 32'h00000000, 32'h00000020, 1'b0});
    vecs.push_back('{"xor",      32'h00004033, 32'h0000F0F0, 32'h0000FF00, 32'h00000000, 32'h00000FF0, 1'b0});
    vecs.push_back('{"or",       32'h00006033, 32'h0000F0F0, 32'h0000FF00, 32'h00000000, 32'h0000FFF0, 1'b0});
    vecs.push_back('{"and",      32'h00007033, 32'h0000F0F0, 32'h0000FF00, 32'h00000000, 32'h0000F000, 1'b0});
    vecs.push_back('{"slt",      32'h00002033, 32'h80000000, 32'h00000000, 32'h00000000, 32'd1,        1'b0});
    vecs.push_back('{"sltu",     32'h00003033, 32'h80000000, 32'h00000000, 32'h00000000, 32'd0,        1'b0});
    vecs.push_back('{"blt",      32'h00004063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"bltu",     32'h00006063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{"bgeu",     32'h00007063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"bge",      32'h00005063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{"bne",      32'h00001063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{"br_f3_010",32'h00002063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{"br_f3_011",32'h00003063, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{"beq_eq",   32'h00000063, 32'h00001234, 32'h00001234, 32'h00000000, 32'h00002468, 1'b1});
    vecs.push_back('{"beq_immneg",32'hFE000EE3,32'h00000000, 32'h00000000, 32'hFFFFFFFC, 32'h00000000, 1'b1});
    // jal -8: fields {1,11111111,1,1111111100,0} sign-extend to 0xFFFFFFF8
    vecs.push_back('{"jal",      32'hFF9FF0EF, 32'h00000100, 32'd4,        32'hFFFFFFF8, 32'h00000104, 1'b0});
    vecs.push_back('{"sw",       32'hFE112E23, 32'h00001000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000FFC, 1'b0});
    vecs.push_back('{"lui",      32'h123452B7, 32'd0,        32'd0,        32'h12345000, 32'h00000000, 1'b0});
    vecs.push_back('{"auipc",    32'hABCDE017, 32'h00001000, 32'hABCDE000, 32'hABCDE000, 32'hABCDF000, 1'b0});
    vecs.push_back('{"lw",       32'hFFC12083, 32'h00000010, 32'd4,        32'hFFFFFFFC, 32'h00000014, 1'b0});
    vecs.push_back('{"jalr",     32'h00C08067, 32'h00000200, 32'd4,        32'h0000000C, 32'h00000204, 1'b0});
    vecs.push_back('{"system",   32'h80000073, 32'd1,        32'd2,        32'hFFFFF800, 32'd3,        1'b0});
    vecs.push_back('{"unknown",  32'h0000007F, 32'd3,        32'd4,        32'h00000000, 32'd7,        1'b0});

    // Reset held low from time zero
    @(negedge clk);
    checkOutput("reset_state", {31'd0, resetn_sync}, 32'd0);

    // Datapath while reset is still asserted
    applyStimulus(32'h40000033, 32'd5, 32'd7);
    checkOutput("sub_in_reset", result, 32'hFFFFFFFE);

    // Release and count two edges
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rel_edge1", {31'd0, resetn_sync}, 32'd0);
    @(negedge clk);
    checkOutput("rel_edge2", {31'd0, resetn_sync}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].instr, vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, "_imm"}, imm, vecs[i].exp_imm);
      checkOutput({vecs[i].name, "_result"}, result, vecs[i].exp_result);
      checkOutput({vecs[i].name, "_take"}, {31'd0, take_b}, {31'd0, vecs[i].exp_take});
    end

    // Mid-cycle pulse must drop resetn_sync before any clock edge
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_assert", {31'd0, resetn_sync}, 32'd0);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("pulse_edge1", {31'd0, resetn_sync}, 32'd0);

    // Reassert after one edge: count restarts from zero
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("restart_edge1", {31'd0, resetn_sync}, 32'd0);
    @(negedge clk);
    checkOutput("restart_edge2", {31'd0, resetn_sync}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
